// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared defaults and pointer sizing for the output FIFO
package ofifo_pkg;
  localparam int def_col = 8;
  localparam int def_psum_bw = 16;
  localparam int def_depth = 8;
  function automatic int ptr_bits(input int d);
    return $clog2(d) + 1;
  endfunction
  localparam int def_ptr_w = ptr_bits(def_depth);
endpackage

// File: rtl/ofifo_if.sv
// ofifo_if: data/strobe/status bundle between the array side and the output FIFO
interface ofifo_if
  import ofifo_pkg::*;
#(
  parameter int col = def_col,
  parameter int psum_bw = def_psum_bw
) ();
  logic [psum_bw*col-1:0] in;
  logic [col-1:0] wr;
  logic rd;
  logic [psum_bw*col-1:0] out;
  logic o_valid;
  logic o_full;
  logic o_ready;
  logic o_overflow;
  modport master (output in, wr, rd, input out, o_valid, o_full, o_ready, o_overflow);
  modport slave (input in, wr, rd, output out, o_valid, o_full, o_ready, o_overflow);
endinterface

// File: rtl/ofifo_lane.sv
// ofifo_lane: one first-word-fall-through lane using wrap-bit pointers
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int psum_bw = def_psum_bw,
  parameter int depth = def_depth
) (
  input  logic clk,
  input  logic reset,
  input  logic [psum_bw-1:0] din,
  input  logic wr,
  input  logic rd,
  output logic [psum_bw-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int pw = ptr_bits(depth);
  localparam int aw = pw - 1;
  logic [pw-1:0] wp, rp;
  logic [psum_bw-1:0] mem [depth];
  logic push, pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[aw], rp[aw-1:0]};
  assign push = wr & ~full;
  assign pop = rd & ~empty;
  assign dout = reset ? '0 : mem[rp[aw-1:0]];
  // entry storage needs no reset; only the pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wp[aw-1:0]] <= din;
  // pointer advance, cleared immediately by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + pw'(1);
      if (pop) rp <= rp + pw'(1);
    end
endmodule

// File: rtl/ofifo.sv
// ofifo: per-column lanes absorbing skewed writes, popped together as full rows
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col = def_col,
  parameter int psum_bw = def_psum_bw,
  parameter int depth = def_depth
) (
  input logic clk,
  input logic reset,
  ofifo_if.slave bus
);
  logic [col-1:0] empty, full;
  logic [psum_bw*col-1:0] out_w;
  logic pop, ovf;
  assign pop = bus.rd & bus.o_valid;
  assign bus.out = out_w;
  assign bus.o_valid = ~|empty;
  assign bus.o_full = |full;
  assign bus.o_ready = ~bus.o_full;
  assign bus.o_overflow = ovf;
  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(.psum_bw(psum_bw), .depth(depth)) u_lane (
      .clk(clk),
      .reset(reset),
      .din(bus.in[psum_bw*g +: psum_bw]),
      .wr(bus.wr[g]),
      .rd(pop),
      .dout(out_w[psum_bw*g +: psum_bw]),
      .empty(empty[g]),
      .full(full[g])
    );
  end
  // sticky flag for any write that hit a full lane
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf <= 1'b0;
    else if (|(bus.wr & full)) ovf <= 1'b1;
endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: directed stimulus with a row scoreboard checked by a pop monitor
module tb_ofifo;
  logic clk, reset;
  int checks = 0, failures = 0, pops = 0, p0;
  logic [127:0] sbq[$];
  logic [127:0] r;

  ofifo_if bus ();
  ofifo dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int k);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'(k * 256 + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    sbq.delete();
    tick();
    reset = 0;
  endtask

  task automatic put(input logic [127:0] v);
    bus.in = v;
    bus.wr = 8'hff;
    sbq.push_back(v);
    tick();
  endtask

  always @(negedge clk)
    if (!reset && bus.rd && bus.o_valid) begin
      pops++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow act=%0h exp=none", bus.out);
      end else chk("pop_data", bus.out, sbq.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 0;
    #3;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_full", bus.o_full, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_out", bus.out, 0);
    tick();
    reset = 0;
    // skewed fill with a growing write mask
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(100 + i);
    bus.in = r;
    for (int c = 0; c < 8; c++) begin
      bus.wr = 8'((2 << c) - 1);
      tick();
      if (c == 6) chk("skew_not_valid", bus.o_valid, 0);
    end
    bus.wr = 0;
    chk("skew_valid", bus.o_valid, 1);
    chk("skew_out", bus.out, r);
    chk("skew_lane0_full", bus.o_full, 1);
    chk("skew_no_ovf", bus.o_overflow, 0);
    sbq.push_back(r);
    bus.rd = 1;
    tick();
    bus.rd = 0;
    chk("skew_after_pop", bus.o_valid, 0);
    // drain three rows with four reads
    do_reset();
    for (int k = 1; k <= 3; k++) put(mk(k));
    bus.wr = 0;
    p0 = pops;
    bus.rd = 1;
    repeat (3) tick();
    chk("drain_empty", bus.o_valid, 0);
    tick();
    bus.rd = 0;
    chk("drain_pops", pops - p0, 3);
    chk("drain_no_ovf", bus.o_overflow, 0);
    bus.in = mk(4);
    bus.wr = 8'hff;
    tick();
    bus.wr = 0;
    chk("drain_next_valid", bus.o_valid, 1);
    chk("drain_next_out", bus.out, mk(4));
    // nine writes into column 0 only
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus.in = mk(k);
      bus.wr = 8'h01;
      tick();
      if (k == 6) chk("ovf_full7", bus.o_full, 0);
      if (k == 7) begin
        chk("ovf_full8", bus.o_full, 1);
        chk("ovf_ready8", bus.o_ready, 0);
        chk("ovf_flag8", bus.o_overflow, 0);
      end
    end
    chk("ovf_flag9", bus.o_overflow, 1);
    for (int k = 0; k < 8; k++) begin
      bus.in = mk(k);
      bus.wr = 8'hfe;
      sbq.push_back(mk(k));
      tick();
    end
    bus.wr = 0;
    p0 = pops;
    bus.rd = 1;
    repeat (9) tick();
    bus.rd = 0;
    chk("ovf_pops", pops - p0, 8);
    chk("ovf_sticky", bus.o_overflow, 1);
    // streaming with pops every cycle, wrapping the pointers
    do_reset();
    chk("ovf_cleared", bus.o_overflow, 0);
    p0 = pops;
    put(mk(20));
    bus.rd = 1;
    for (int k = 1; k < 20; k++) begin
      put(mk(20 + k));
      chk("wrap_not_full", bus.o_full, 0);
    end
    bus.wr = 0;
    tick();
    bus.rd = 0;
    chk("wrap_empty", bus.o_valid, 0);
    chk("wrap_pops", pops - p0, 20);
    // simultaneous write and pop at occupancy four
    do_reset();
    p0 = pops;
    for (int k = 0; k < 4; k++) put(mk(50 + k));
    bus.rd = 1;
    for (int k = 0; k < 10; k++) put(mk(60 + k));
    bus.wr = 0;
    repeat (3) tick();
    chk("sim_still_valid", bus.o_valid, 1);
    tick();
    bus.rd = 0;
    chk("sim_empty", bus.o_valid, 0);
    chk("sim_pops", pops - p0, 14);
    // reset between edges with rows queued
    do_reset();
    for (int k = 0; k < 5; k++) put(mk(70 + k));
    bus.wr = 0;
    chk("mid_valid", bus.o_valid, 1);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_ready", bus.o_ready, 1);
    chk("mid_rst_out", bus.out, 0);
    sbq.delete();
    #2;
    reset = 0;
    bus.in = mk(99);
    bus.wr = 8'hff;
    tick();
    bus.wr = 0;
    chk("mid_new_valid", bus.o_valid, 1);
    chk("mid_new_out", bus.out, mk(99));
    sbq.push_back(mk(99));
    bus.rd = 1;
    tick();
    bus.rd = 0;
    chk("mid_new_popped", bus.o_valid, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
